// File: rtl/tinyalu_arbiter.sv
// Round-robin arbiter sharing one TinyALU between two requesters.
// Optional start/done watchdog enabled by defining TINYALU_ARB_TIMEOUT_EN.
module tinyalu_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic [5:0]  req_op,
    output logic [1:0]  resp_valid,
    output logic [15:0] resp_result,
    output logic        resp_err,
    output logic        alu_start,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_op,
    input  logic        alu_done,
    input  logic [15:0] alu_result
);

    // state | meaning
    // IDLE  | arbitrating, req_ready = round-robin grant
    // ISSUE | alu_start held with captured operands until alu_done
    // RESP  | one-cycle resp_valid pulse to the owner
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic        owner_q, owner_d;
    logic        armed_q, armed_d;
    logic [7:0]  a_q, a_d, b_q, b_d;
    logic [2:0]  op_q, op_d;
    logic        start_q, start_d;
    logic [1:0]  rv_q, rv_d;
    logic [15:0] res_q, res_d;
    logic [1:0]  grant;
    logic        sel;
    logic [2:0]  sel_op;
`ifdef TINYALU_ARB_TIMEOUT_EN
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;
`else
    logic        unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
`endif

    // armed_q keeps req_ready low until the first edge after reset release
    always_comb begin
        grant = 2'b00;
        if (state_q == IDLE && armed_q) begin
            if (req_valid == 2'b11) grant = last_q ? 2'b01 : 2'b10;
            else                    grant = req_valid;
        end
    end

    assign sel    = grant[1];
    assign sel_op = sel ? req_op[5:3] : req_op[2:0];

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        armed_d = 1'b1;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        start_d = start_q;
        rv_d    = 2'b00;
        res_d   = res_q;
`ifdef TINYALU_ARB_TIMEOUT_EN
        err_d   = err_q;
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (|grant) begin
                    owner_d = sel;
                    last_d  = sel;
                    a_d     = sel ? req_a[15:8] : req_a[7:0];
                    b_d     = sel ? req_b[15:8] : req_b[7:0];
                    op_d    = sel_op;
`ifdef TINYALU_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
                    cnt_d   = 8'(TIMEOUT - 1);
`endif
                    if (sel_op == 3'b000) begin
                        state_d = RESP;
                        res_d   = 16'h0000;
                        rv_d    = grant;
                    end else begin
                        state_d = ISSUE;
                        start_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (alu_done) begin
                    state_d = RESP;
                    start_d = 1'b0;
                    res_d   = alu_result;
                    rv_d    = owner_q ? 2'b10 : 2'b01;
                end
`ifdef TINYALU_ARB_TIMEOUT_EN
                else if (cnt_q == 8'd0) begin
                    state_d = RESP;
                    start_d = 1'b0;
                    res_d   = 16'h0000;
                    err_d   = 1'b1;
                    rv_d    = owner_q ? 2'b10 : 2'b01;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
`endif
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            armed_q <= 1'b0;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            op_q    <= 3'b000;
            start_q <= 1'b0;
            rv_q    <= 2'b00;
            res_q   <= 16'h0000;
`ifdef TINYALU_ARB_TIMEOUT_EN
            err_q   <= 1'b0;
            cnt_q   <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            armed_q <= armed_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            start_q <= start_d;
            rv_q    <= rv_d;
            res_q   <= res_d;
`ifdef TINYALU_ARB_TIMEOUT_EN
            err_q   <= err_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign req_ready   = grant;
    assign alu_start   = start_q;
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_op      = op_q;
    assign resp_valid  = rv_q;
    assign resp_result = res_q;
`ifdef TINYALU_ARB_TIMEOUT_EN
    assign resp_err    = err_q;
`else
    assign resp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_tinyalu_arbiter.sv
// Scoreboard bench for tinyalu_arbiter with a behavioural TinyALU responder.
module tb_tinyalu_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_a, req_b;
    logic [5:0]  req_op;
    logic [1:0]  resp_valid;
    logic [15:0] resp_result;
    logic        resp_err;
    logic        alu_start;
    logic [7:0]  alu_a, alu_b;
    logic [2:0]  alu_op;
    logic        alu_done;
    logic [15:0] alu_result;

    typedef struct packed {
        logic [1:0]  owner;
        logic [15:0] res;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   resp_count = 0;
    logic alu_en;
    logic spur;
    int   lat;
    localparam int LAT = 3;

    tinyalu_arbiter #(.TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .resp_valid(resp_valid), .resp_result(resp_result), .resp_err(resp_err),
        .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_done(alu_done), .alu_result(alu_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] calc(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        case (op)
            3'b001:  return 16'(a) + 16'(b);
            3'b010:  return {8'h00, a & b};
            3'b011:  return {8'h00, a ^ b};
            3'b100:  return 16'(a) * 16'(b);
            default: return 16'h0000;
        endcase
    endfunction

    // TinyALU responder: done LAT cycles after start is seen, sampled on negedge
    initial begin
        alu_done = 1'b0;
        alu_result = 16'h0000;
        lat = 0;
        forever begin
            @(negedge clk);
            if (spur) begin
                alu_done = 1'b1;
                alu_result = 16'hDEAD;
                spur = 1'b0;
            end else if (alu_done) begin
                alu_done = 1'b0;
            end else if (alu_en && alu_start) begin
                lat++;
                if (lat == LAT) begin
                    alu_done = 1'b1;
                    alu_result = calc(alu_a, alu_b, alu_op);
                    lat = 0;
                end
            end else if (!alu_start) begin
                lat = 0;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && resp_valid != 2'b00) begin
                resp_count++;
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_resp: got resp_valid %b result %h expected none", resp_valid, resp_result);
                end else begin
                    e = sb.pop_front();
                    check("resp_owner", 32'(resp_valid), 32'(e.owner));
                    check("resp_result", 32'(resp_result), 32'(e.res));
                    check("resp_err", 32'(resp_err), 32'(e.err));
                    check("start_low_in_resp", 32'(alu_start), 0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench time limit");
    end

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        req_a[8*i +: 8] = a;
        req_b[8*i +: 8] = b;
        req_op[3*i +: 3] = op;
    endtask

    // returns at accept edge + #1; optionally drops the requester's valid
    task automatic wait_accept(input int i, input bit drop);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (req_ready[i] && req_valid[i]) begin
                @(posedge clk);
                #1;
                if (drop) req_valid[i] = 1'b0;
                return;
            end
        end
        vectors++;
        miscompares++;
        $display("FAIL accept_timeout: got no accept expected accept of requester %0d", i);
    endtask

    task automatic drain();
        int n;
        for (n = 0; n < 300; n++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        if (n == 300) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int c0, n;
        reset_n = 1'b0;
        req_valid = 2'b11;
        req_a = '0; req_b = '0; req_op = '0;
        alu_en = 1'b1;
        spur = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 0);
        check("rst_start", 32'(alu_start), 0);
        check("rst_alu_ops", 32'({alu_a, alu_b, alu_op}), 0);
        check("rst_resp", 32'({resp_valid, resp_result, resp_err}), 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("ready_before_clk", 32'(req_ready), 0);
        @(posedge clk);
        #1;
        check("first_tie_req0", 32'(req_ready), 1);
        req_valid = 2'b00;
        repeat (2) @(posedge clk);
        #1;

        // requester 0 add
        set_req(0, 8'h12, 8'h34, 3'b001);
        sb.push_back('{2'b01, 16'h0046, 1'b0});
        req_valid[0] = 1'b1;
        wait_accept(0, 1);
        check("add_start", 32'(alu_start), 1);
        check("add_ops", 32'({alu_a, alu_b, alu_op}), 32'({8'h12, 8'h34, 3'b001}));
        @(posedge clk);
        #1;
        check("add_start_held", 32'(alu_start), 1);
        check("add_ready_low", 32'(req_ready), 0);
        drain();

        // requester 1 no_op
        set_req(1, 8'hAA, 8'h55, 3'b000);
        sb.push_back('{2'b10, 16'h0000, 1'b0});
        req_valid[1] = 1'b1;
        wait_accept(1, 1);
        check("noop_resp_timing", 32'(resp_valid), 2);
        check("noop_no_start", 32'(alu_start), 0);
        @(posedge clk);
        #1;
        check("noop_no_start2", 32'(alu_start), 0);
        check("noop_pulse_len", 32'(resp_valid), 0);
        drain();

        // both continuously valid: grants 0,1,0,1
        set_req(0, 8'hFF, 8'hFF, 3'b100);
        set_req(1, 8'hF0, 8'h0F, 3'b011);
        sb.push_back('{2'b01, 16'hFE01, 1'b0});
        sb.push_back('{2'b10, 16'h00FF, 1'b0});
        sb.push_back('{2'b01, 16'h0003, 1'b0});
        sb.push_back('{2'b10, 16'h0008, 1'b0});
        req_valid = 2'b11;
        wait_accept(0, 0);
        set_req(0, 8'h01, 8'h02, 3'b001);
        wait_accept(1, 0);
        set_req(1, 8'h0C, 8'h0A, 3'b010);
        wait_accept(0, 1);
        wait_accept(1, 1);
        drain();

        // spurious done in IDLE
        c0 = resp_count;
        spur = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("spur_no_resp", 32'(resp_count), 32'(c0));
        check("spur_no_start", 32'(alu_start), 0);

        // reset during ISSUE
        set_req(0, 8'h07, 8'h09, 3'b001);
        req_valid[0] = 1'b1;
        wait_accept(0, 1);
        check("pre_reset_start", 32'(alu_start), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("reset_start_low", 32'(alu_start), 0);
        check("reset_no_resp", 32'(resp_valid), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        set_req(0, 8'h01, 8'h01, 3'b001);
        sb.push_back('{2'b01, 16'h0002, 1'b0});
        req_valid[0] = 1'b1;
        wait_accept(0, 1);
        drain();

`ifdef TINYALU_ARB_TIMEOUT_EN
        alu_en = 1'b0;
        set_req(0, 8'h05, 8'h06, 3'b001);
        sb.push_back('{2'b01, 16'h0000, 1'b1});
        req_valid[0] = 1'b1;
        wait_accept(0, 1);
        n = 0;
        while (alu_start && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
        check("timeout_start_cycles", 32'(n), 16);
        drain();
        alu_en = 1'b1;
`endif

        drain();
        check("sb_empty", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
